// File: rtl/mips_cycle_sequencer.sv
// Phase sequencer for the multicycle MIPS core: run / single-step / halt-at-boundary with prescaled pacing.
// Optional breakpoint-on-instruction-count support is enabled by defining SEQ_BREAKPOINT_EN.
module mips_cycle_sequencer #(
    parameter int NUM_STATES = 7,
    parameter int PRESCALE   = 50000000,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 run_mode,
    input  logic                 step_req,
    input  logic                 fast,
    input  logic                 halt_req,
    input  logic                 resume,
`ifdef SEQ_BREAKPOINT_EN
    input  logic                 bp_valid,
    input  logic [CNT_WIDTH-1:0] bp_count,
`endif
    output logic [2:0]           count_state,
    output logic                 state_adv,
    output logic                 instr_done,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [1:0]           seq_state,
    output logic                 busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [2:0] LAST_PHASE = 3'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } seq_t;

    seq_t                 state;
    logic [PS_W-1:0]      prescaler;
    logic                 halt_latch;
    logic                 step_req_d;
    logic                 step_rise;
    logic                 halt_pending;
    logic                 tick;
    logic                 wrap;
    logic                 bp_hit;
    logic [CNT_WIDTH-1:0] instr_next;

    assign step_rise    = step_req & ~step_req_d;
    assign halt_pending = halt_latch | halt_req;
    assign tick         = enable & (fast | (prescaler == PS_LAST));
    assign wrap         = (count_state == LAST_PHASE);
    assign instr_next   = instr_count + 1'b1;
    assign seq_state    = state;
    assign busy         = (state == RUN) || (state == STEP);

`ifdef SEQ_BREAKPOINT_EN
    assign bp_hit = bp_valid && (instr_next == bp_count);
`else
    assign bp_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            count_state <= 3'd0;
            state_adv   <= 1'b0;
            instr_done  <= 1'b0;
            instr_count <= '0;
            prescaler   <= '0;
            halt_latch  <= 1'b0;
            step_req_d  <= 1'b0;
        end else begin
            step_req_d <= step_req;
            state_adv  <= 1'b0;
            instr_done <= 1'b0;
            if (halt_req)
                halt_latch <= 1'b1;

            case (state)
                IDLE: begin
                    if (halt_pending) begin
                        state <= HALTED;
                    end else if (enable && run_mode) begin
                        state     <= RUN;
                        prescaler <= '0;
                    end else if (enable && !run_mode && step_rise) begin
                        state     <= STEP;
                        prescaler <= '0;
                    end
                end

                RUN, STEP: begin
                    if (enable) begin
                        if (!fast)
                            prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
                        if (tick) begin
                            state_adv <= 1'b1;
                            if (wrap) begin
                                count_state <= 3'd0;
                                instr_done  <= 1'b1;
                                instr_count <= instr_next;
                                // Exit decisions only at the instruction boundary, never mid-instruction.
                                if (bp_hit) begin
                                    halt_latch <= 1'b1;
                                    state      <= HALTED;
                                end else if (halt_pending) begin
                                    state <= HALTED;
                                end else if (state == STEP || !run_mode) begin
                                    state <= IDLE;
                                end
                            end else begin
                                count_state <= count_state + 3'd1;
                            end
                        end
                    end
                end

                HALTED: begin
                    count_state <= 3'd0;
                    // A simultaneous halt_req keeps the sequencer halted with the latch set.
                    if (resume && !halt_req) begin
                        state      <= IDLE;
                        halt_latch <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Directed self-checking bench for mips_cycle_sequencer (NUM_STATES=7, PRESCALE=4, CNT_WIDTH=4).
module tb_mips_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset, enable, run_mode, step_req, fast, halt_req, resume;
    logic [2:0] count_state;
    logic       state_adv, instr_done, busy;
    logic [3:0] instr_count;
    logic [1:0] seq_state;
`ifdef SEQ_BREAKPOINT_EN
    logic       bp_valid;
    logic [3:0] bp_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cycle_sequencer #(.NUM_STATES(7), .PRESCALE(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .run_mode(run_mode),
        .step_req(step_req), .fast(fast), .halt_req(halt_req), .resume(resume),
`ifdef SEQ_BREAKPOINT_EN
        .bp_valid(bp_valid), .bp_count(bp_count),
`endif
        .count_state(count_state), .state_adv(state_adv), .instr_done(instr_done),
        .instr_count(instr_count), .seq_state(seq_state), .busy(busy)
    );

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; run_mode = 1'b0; step_req = 1'b0;
        fast = 1'b0; halt_req = 1'b0; resume = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
        bp_valid = 1'b0; bp_count = 4'd0;
`endif
        clks(2);
        checks++; if (count_state !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count_state); end
        checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL rst_seq got %0d exp 0", seq_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL rst_icount got %0d exp 0", instr_count); end
        checks++; if ({state_adv, instr_done} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {state_adv, instr_done}); end
    endtask

    task automatic test_run_fast();
        reset = 1'b1; enable = 1'b1; run_mode = 1'b1; fast = 1'b1;
        clks(1);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd0) begin errors++; $display("FAIL run_enter got seq %0d cs %0d exp seq 1 cs 0", seq_state, count_state); end
        for (int i = 1; i <= 21; i++) begin
            clks(1);
            checks++; if (count_state !== 3'(i % 7)) begin errors++; $display("FAIL run_phase[%0d] got %0d exp %0d", i, count_state, i % 7); end
            checks++; if (instr_done !== (i % 7 == 0)) begin errors++; $display("FAIL run_done[%0d] got %0b exp %0b", i, instr_done, (i % 7 == 0)); end
            checks++; if (state_adv !== 1'b1) begin errors++; $display("FAIL run_adv[%0d] got %0b exp 1", i, state_adv); end
        end
        checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL run_icount got %0d exp 3", instr_count); end
        run_mode = 1'b0;
        clks(6);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd6) begin errors++; $display("FAIL run_finish_mid got seq %0d cs %0d exp seq 1 cs 6", seq_state, count_state); end
        clks(1);
        checks++; if (seq_state !== 2'd0 || count_state !== 3'd0 || instr_count !== 4'd4) begin errors++; $display("FAIL run_stop got seq %0d cs %0d ic %0d exp 0 0 4", seq_state, count_state, instr_count); end
    endtask

    task automatic test_prescale();
        fast = 1'b0; run_mode = 1'b1;
        clks(1);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd0) begin errors++; $display("FAIL ps_enter got seq %0d cs %0d exp 1 0", seq_state, count_state); end
        clks(3);
        checks++; if (count_state !== 3'd0 || state_adv !== 1'b0) begin errors++; $display("FAIL ps_wait got cs %0d adv %0b exp 0 0", count_state, state_adv); end
        clks(1);
        checks++; if (count_state !== 3'd1 || state_adv !== 1'b1) begin errors++; $display("FAIL ps_adv got cs %0d adv %0b exp 1 1", count_state, state_adv); end
        clks(2);
        enable = 1'b0;
        clks(10);
        checks++; if (count_state !== 3'd1 || state_adv !== 1'b0 || seq_state !== 2'd1) begin errors++; $display("FAIL ps_freeze got cs %0d adv %0b seq %0d exp 1 0 1", count_state, state_adv, seq_state); end
        enable = 1'b1;
        clks(1);
        checks++; if (count_state !== 3'd1) begin errors++; $display("FAIL ps_resume1 got %0d exp 1", count_state); end
        clks(1);
        checks++; if (count_state !== 3'd2 || state_adv !== 1'b1) begin errors++; $display("FAIL ps_resume2 got cs %0d adv %0b exp 2 1", count_state, state_adv); end
        run_mode = 1'b0; fast = 1'b1;
        clks(5);
        checks++; if (seq_state !== 2'd0 || count_state !== 3'd0 || instr_count !== 4'd5) begin errors++; $display("FAIL ps_stop got seq %0d cs %0d ic %0d exp 0 0 5", seq_state, count_state, instr_count); end
    endtask

    task automatic test_step();
        step_req = 1'b1;
        clks(1);
        checks++; if (seq_state !== 2'd2 || busy !== 1'b1 || count_state !== 3'd0) begin errors++; $display("FAIL step_enter got seq %0d busy %0b cs %0d exp 2 1 0", seq_state, busy, count_state); end
        clks(6);
        checks++; if (seq_state !== 2'd2 || count_state !== 3'd6) begin errors++; $display("FAIL step_mid got seq %0d cs %0d exp 2 6", seq_state, count_state); end
        clks(1);
        checks++; if (seq_state !== 2'd0 || count_state !== 3'd0 || instr_count !== 4'd6 || instr_done !== 1'b1) begin errors++; $display("FAIL step_done got seq %0d cs %0d ic %0d done %0b exp 0 0 6 1", seq_state, count_state, instr_count, instr_done); end
        clks(10);
        checks++; if (seq_state !== 2'd0 || instr_count !== 4'd6 || busy !== 1'b0) begin errors++; $display("FAIL step_hold got seq %0d ic %0d busy %0b exp 0 6 0", seq_state, instr_count, busy); end
        step_req = 1'b0;
        clks(1);
    endtask

    task automatic test_halt();
        run_mode = 1'b1;
        clks(4);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd3) begin errors++; $display("FAIL halt_pre got seq %0d cs %0d exp 1 3", seq_state, count_state); end
        halt_req = 1'b1;
        clks(1);
        halt_req = 1'b0;
        clks(2);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd6) begin errors++; $display("FAIL halt_finish got seq %0d cs %0d exp 1 6", seq_state, count_state); end
        clks(1);
        checks++; if (seq_state !== 2'd3 || count_state !== 3'd0 || instr_count !== 4'd7 || instr_done !== 1'b1) begin errors++; $display("FAIL halt_enter got seq %0d cs %0d ic %0d done %0b exp 3 0 7 1", seq_state, count_state, instr_count, instr_done); end
        clks(3);
        checks++; if (seq_state !== 2'd3 || count_state !== 3'd0 || state_adv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL halt_hold got seq %0d cs %0d adv %0b busy %0b exp 3 0 0 0", seq_state, count_state, state_adv, busy); end
        halt_req = 1'b1; resume = 1'b1;
        clks(1);
        checks++; if (seq_state !== 2'd3) begin errors++; $display("FAIL halt_wins got seq %0d exp 3", seq_state); end
        halt_req = 1'b0;
        clks(1);
        resume = 1'b0;
        checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL halt_resume got seq %0d exp 0", seq_state); end
        clks(1);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd0) begin errors++; $display("FAIL halt_rerun got seq %0d cs %0d exp 1 0", seq_state, count_state); end
    endtask

    task automatic test_reset_mid();
        clks(5);
        checks++; if (count_state !== 3'd5) begin errors++; $display("FAIL rmid_pre got %0d exp 5", count_state); end
        reset = 1'b0;
        clks(1);
        checks++; if (count_state !== 3'd0 || seq_state !== 2'd0 || busy !== 1'b0 || instr_count !== 4'd0 || state_adv !== 1'b0 || instr_done !== 1'b0) begin errors++; $display("FAIL rmid_reset got cs %0d seq %0d busy %0b ic %0d adv %0b done %0b exp all 0", count_state, seq_state, busy, instr_count, state_adv, instr_done); end
        reset = 1'b1;
        clks(1);
        checks++; if (seq_state !== 2'd1 || count_state !== 3'd0) begin errors++; $display("FAIL rmid_restart got seq %0d cs %0d exp 1 0", seq_state, count_state); end
        clks(1);
        checks++; if (count_state !== 3'd1) begin errors++; $display("FAIL rmid_first got %0d exp 1", count_state); end
    endtask

    task automatic test_count_wrap();
        clks(6);
        checks++; if (instr_count !== 4'd1 || count_state !== 3'd0) begin errors++; $display("FAIL wrap_first got ic %0d cs %0d exp 1 0", instr_count, count_state); end
        clks(98);
        checks++; if (instr_count !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d exp 15", instr_count); end
        clks(7);
        checks++; if (instr_count !== 4'd0 || instr_done !== 1'b1) begin errors++; $display("FAIL wrap_zero got ic %0d done %0b exp 0 1", instr_count, instr_done); end
        run_mode = 1'b0;
        clks(7);
        checks++; if (seq_state !== 2'd0 || instr_count !== 4'd1) begin errors++; $display("FAIL wrap_stop got seq %0d ic %0d exp 0 1", seq_state, instr_count); end
    endtask

`ifdef SEQ_BREAKPOINT_EN
    task automatic test_breakpoint();
        bp_valid = 1'b1; bp_count = 4'd3; run_mode = 1'b1;
        clks(1);
        clks(7);
        checks++; if (seq_state !== 2'd1 || instr_count !== 4'd2) begin errors++; $display("FAIL bp_pass got seq %0d ic %0d exp 1 2", seq_state, instr_count); end
        clks(7);
        checks++; if (seq_state !== 2'd3 || instr_count !== 4'd3 || count_state !== 3'd0) begin errors++; $display("FAIL bp_hit got seq %0d ic %0d cs %0d exp 3 3 0", seq_state, instr_count, count_state); end
        clks(5);
        checks++; if (seq_state !== 2'd3 || instr_count !== 4'd3 || state_adv !== 1'b0) begin errors++; $display("FAIL bp_hold got seq %0d ic %0d adv %0b exp 3 3 0", seq_state, instr_count, state_adv); end
        bp_valid = 1'b0; resume = 1'b1; run_mode = 1'b0;
        clks(1);
        resume = 1'b0;
        checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL bp_resume got seq %0d exp 0", seq_state); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_fast();
        test_prescale();
        test_step();
        test_halt();
        test_reset_mid();
        test_count_wrap();
`ifdef SEQ_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cycle_sequencer.md
Name: mips_cycle_sequencer

Overview:
Sequencer for the multicycle MIPS core. It replaces the free-running machine-cycle counter and produces the `count_state` phase (0..NUM_STATES-1) that steps the core through its multicycle phases. Supports continuous run, single-instruction step and halt-at-boundary, with optional prescaled pacing for board-level observation on LEDs.

Parameters:
NUM_STATES, 7, machine-cycle phases per instruction; count_state runs 0..NUM_STATES-1, min 2, max 8.
PRESCALE, 50000000, clk cycles per phase advance when fast=0; min 1.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset; sampled on clk rising edge.
enable  in  1  global advance enable; low freezes phase and prescaler.
run_mode  in  1  1 = continuous run, 0 = step mode.
step_req  in  1  level from a debounced button; the rising edge requests one instruction.
fast  in  1  1 = advance every tick-enabled clk; 0 = advance every PRESCALE clks.
halt_req  in  1  pulse or level; sticky request to halt at the next instruction boundary.
resume  in  1  leaves HALTED and clears the halt latch.
count_state  out  3  current machine-cycle phase to the MIPS core.
state_adv  out  1  one-clk pulse in the cycle count_state shows a new value.
instr_done  out  1  one-clk pulse in the cycle count_state wraps to 0.
instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.
seq_state  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3.
busy  out  1  high in RUN or STEP.

Behaviour:
- Reset (reset=0 at clk edge): count_state=0, state_adv=0, instr_done=0, instr_count=0, seq_state=IDLE, busy=0, prescaler=0, halt latch=0, step edge register=0.
- step edge: `step_rise = step_req & ~step_req_d`, where step_req_d is registered every clk. Step edges are ignored outside IDLE.
- halt latch: set by halt_req=1 in any state. Cleared only by resume in HALTED or by reset.
- tick: if fast=1, tick=enable. Otherwise the prescaler counts 0..PRESCALE-1 while busy&enable, and tick=1 when prescaler==PRESCALE-1 & enable. The prescaler then returns to 0. It holds when enable=0 and clears to 0 on every entry to RUN or STEP.
- Advance: on a tick in RUN/STEP, count_state←count_state+1, or 0 if it was NUM_STATES-1. The update is registered, so a tick at cycle N gives the new count_state at N+1. state_adv=1 at N+1, and instr_done=1 at N+1 on a wrap. instr_count increments in the same cycle as instr_done.
- IDLE: count_state holds (always 0 after a completed instruction). Transitions, in priority order:
  - halt latch set → HALTED.
  - enable&run_mode → RUN.
  - enable&~run_mode&step_rise → STEP.
- RUN: advance on tick. Exit decisions are made only on the wrap tick (new count_state=0), in priority order:
  - halt latch → HALTED.
  - ~run_mode → IDLE.
  - otherwise stay in RUN.
  - halt_req arriving mid-instruction never truncates the instruction.
- STEP: advance through exactly NUM_STATES phases. On the wrap tick go to HALTED if the halt latch is set, else IDLE.
- HALTED: count_state=0, no advance. resume=1 → IDLE and clears the latch. If halt_req and resume are both high in the same cycle, the halt wins: stay HALTED, latch stays set.
- enable=0 mid-instruction: seq_state, count_state and prescaler all hold; no pulses.
- reset during any state: full return to reset values on that edge, regardless of enable.
- instr_count wrap: from 2^CNT_WIDTH-1 to 0; no flag.

Optional Feature:
Macro SEQ_BREAKPOINT_EN.
- Defined: adds inputs bp_valid (1 bit) and bp_count (CNT_WIDTH bits). When bp_valid=1 and an instr_done occurs whose incremented instr_count equals bp_count, the sequencer sets the halt latch and enters HALTED in that same transition. This takes precedence over RUN/IDLE continuation. resume clears it as a normal halt.
- Undefined: the ports are absent, with no breakpoint logic.

Test Plan:
1. NUM_STATES=7, fast=1, run_mode=1, enable=1 after reset → count_state 0,1,..,6,0,…; instr_done every 7 clks; instr_count=3 after 21 advances.
2. fast=0, PRESCALE=4, RUN → count_state changes every 4 clks. Drop enable for 10 clks mid-phase → no change. On restore, the remaining prescale count completes.
3. run_mode=0, step_req pulse 0→1 → seq_state=STEP. After 7 ticks, count_state=0, instr_count=1, seq_state=IDLE. Holding step_req high gives no second instruction.
4. RUN, halt_req pulsed at count_state=3 → phases 4,5,6 complete, then HALTED with count_state=0. resume → IDLE, then RUN.
5. Assert reset=0 at count_state=5 in RUN → next clk all outputs at reset values. reset=1 with enable=1, run_mode=1 → RUN restarts from 0.
6. (SEQ_BREAKPOINT_EN) bp_valid=1, bp_count=2, RUN fast → HALTED on the wrap that makes instr_count=2; no further advance until resume.
